// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and default depths for the elastic buffers between pipeline stages.
// Also provides a pointer-width helper that stays legal for a single-entry buffer.
package pipe_stage_buffer_pkg;

  typedef struct packed {
    int unsigned width;
    int unsigned depth;
    logic        fall_through;
  } pipe_buf_cfg_t;

  localparam int unsigned IF_ID_BUF_DEPTH  = 2;
  localparam int unsigned ID_RR_BUF_DEPTH  = 2;
  localparam int unsigned RR_EXE_BUF_DEPTH = 2;
  localparam int unsigned EXE_WB_BUF_DEPTH = 1;

  localparam pipe_buf_cfg_t PIPE_BUF_DEFAULT_CFG = '{width: 64, depth: 2, fall_through: 1'b0};

  // A single-entry buffer still needs a 1-bit pointer so the port widths stay legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Reused by the buffer stall counter and the core perf counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// DEPTH-entry valid/ready FIFO placed between two pipeline stages, with optional
// fall-through on empty, full flush and a saturating backpressure counter.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  input  logic                       stall_clr_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = ptr_width(DEPTH);
  // A 1-entry buffer gets a never-written spare word so the 1-bit pointer indexes a 2-entry array.
  localparam int unsigned MEM_N = (DEPTH < 2) ? 2 : DEPTH;

  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [WIDTH-1:0] mem_d [MEM_N];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, bypass, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign ready_o = !full;
  assign bypass  = FALL_THROUGH && empty && valid_i && ready_i && !flush_i;
  assign valid_o = FALL_THROUGH ? ((!empty || valid_i) && !flush_i) : (!empty && !flush_i);
  assign data_o  = (FALL_THROUGH && empty) ? data_i : mem_q[rd_ptr_q];
  assign push    = valid_i && ready_o && !flush_i && !bypass;
  assign pop     = valid_o && ready_i && !flush_i && !bypass;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_i && !ready_o && !flush_i),
    .clr_i (stall_clr_i),
    .cnt_o (stall_cnt_o)
  );

  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;

  a_no_push_full:  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_no_pop_empty:  assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));
  a_count_bound:   assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CW'(DEPTH));
  // Upstream must hold an unaccepted entry unchanged until it is taken.
  a_upstream_hold: assert property (@(posedge clk_i) disable iff (rst_i)
                     (valid_i && !flush_i && !push && !bypass) |=> (valid_i && $stable(data_i)));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a vector table for DEPTH=2 registered mode,
// plus sequences for wrap-around, fall-through, stall saturation and mid-stream reset.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=2, registered
  logic a_flush, a_valid, a_ready, a_clr, a_ready_o, a_valid_o, a_empty, a_full;
  logic [63:0] a_data, a_data_o;
  logic [1:0]  a_count;
  logic [15:0] a_stall;

  // Instance B: DEPTH=3, registered
  logic b_flush, b_valid, b_ready, b_clr, b_ready_o, b_valid_o, b_empty, b_full;
  logic [7:0]  b_data, b_data_o;
  logic [1:0]  b_count;
  logic [15:0] b_stall;

  // Instance C: DEPTH=2, fall-through
  logic c_flush, c_valid, c_ready, c_clr, c_ready_o, c_valid_o, c_empty, c_full;
  logic [7:0]  c_data, c_data_o;
  logic [1:0]  c_count;
  logic [15:0] c_stall;

  // Instance D: DEPTH=1, 4-bit stall counter
  logic d_flush, d_valid, d_ready, d_clr, d_ready_o, d_valid_o, d_empty, d_full;
  logic [7:0]  d_data, d_data_o;
  logic [0:0]  d_count;
  logic [3:0]  d_stall;

  pipe_stage_buffer #(.WIDTH(64), .DEPTH(2), .FALL_THROUGH(1'b0), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .valid_i(a_valid), .data_i(a_data),
    .ready_o(a_ready_o), .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready),
    .count_o(a_count), .empty_o(a_empty), .full_o(a_full), .stall_cnt_o(a_stall),
    .stall_clr_i(a_clr));

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .valid_i(b_valid), .data_i(b_data),
    .ready_o(b_ready_o), .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready),
    .count_o(b_count), .empty_o(b_empty), .full_o(b_full), .stall_cnt_o(b_stall),
    .stall_clr_i(b_clr));

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b1), .CNT_W(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .valid_i(c_valid), .data_i(c_data),
    .ready_o(c_ready_o), .valid_o(c_valid_o), .data_o(c_data_o), .ready_i(c_ready),
    .count_o(c_count), .empty_o(c_empty), .full_o(c_full), .stall_cnt_o(c_stall),
    .stall_clr_i(c_clr));

  pipe_stage_buffer #(.WIDTH(8), .DEPTH(1), .FALL_THROUGH(1'b0), .CNT_W(4)) dut_d (
    .clk_i(clk), .rst_i(rst), .flush_i(d_flush), .valid_i(d_valid), .data_i(d_data),
    .ready_o(d_ready_o), .valid_o(d_valid_o), .data_o(d_data_o), .ready_i(d_ready),
    .count_o(d_count), .empty_o(d_empty), .full_o(d_full), .stall_cnt_o(d_stall),
    .stall_clr_i(d_clr));

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        fl;
    logic        chk_d;
    logic        e_vo;
    logic [63:0] e_do;
    logic        e_ro;
    logic [1:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t vec);
    a_valid = vec.v;
    a_data  = vec.d;
    a_ready = vec.r;
    a_flush = vec.fl;
  endtask

  initial begin
    int k, got, mcnt;
    logic acc, pop, exp_ro, exp_vo;

    {a_flush, a_valid, a_ready, a_clr} = '0; a_data = '0;
    {b_flush, b_valid, b_ready, b_clr} = '0; b_data = '0;
    {c_flush, c_valid, c_ready, c_clr} = '0; c_data = '0;
    {d_flush, d_valid, d_ready, d_clr} = '0; d_data = '0;

    //            v  d       r  fl chk vo do      ro cnt full empty stall
    vecs[0]  = '{0, 64'h0,  0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[1]  = '{1, 64'hA,  0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[2]  = '{1, 64'hB,  0, 0, 1, 1, 64'hA,  1, 1, 0, 0, 0};
    vecs[3]  = '{0, 64'h0,  0, 0, 1, 1, 64'hA,  0, 2, 1, 0, 0};
    vecs[4]  = '{0, 64'h0,  1, 0, 1, 1, 64'hA,  0, 2, 1, 0, 0};
    vecs[5]  = '{0, 64'h0,  1, 0, 1, 1, 64'hB,  1, 1, 0, 0, 0};
    vecs[6]  = '{0, 64'h0,  0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[7]  = '{1, 64'h11, 0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[8]  = '{1, 64'h22, 0, 0, 1, 1, 64'h11, 1, 1, 0, 0, 0};
    vecs[9]  = '{1, 64'h33, 1, 1, 0, 0, 64'h0,  0, 2, 1, 0, 0};
    vecs[10] = '{0, 64'h0,  1, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[11] = '{1, 64'h44, 0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};
    vecs[12] = '{0, 64'h0,  1, 0, 1, 1, 64'h44, 1, 1, 0, 0, 0};
    vecs[13] = '{0, 64'h0,  0, 0, 0, 0, 64'h0,  1, 0, 0, 1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_valid_o", a_valid_o, 0);
    checkOutput("rst_ready_o", a_ready_o, 1);
    checkOutput("rst_empty_o", a_empty, 1);
    checkOutput("rst_full_o", a_full, 0);
    checkOutput("rst_count_o", a_count, 0);
    checkOutput("rst_stall_o", a_stall, 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_valid_o", i), a_valid_o, vecs[i].e_vo);
      if (vecs[i].chk_d) checkOutput($sformatf("vec%0d_data_o", i), a_data_o, vecs[i].e_do);
      checkOutput($sformatf("vec%0d_ready_o", i), a_ready_o, vecs[i].e_ro);
      checkOutput($sformatf("vec%0d_count_o", i), a_count, vecs[i].e_cnt);
      checkOutput($sformatf("vec%0d_full_o", i), a_full, vecs[i].e_full);
      checkOutput($sformatf("vec%0d_empty_o", i), a_empty, vecs[i].e_empty);
      checkOutput($sformatf("vec%0d_stall", i), a_stall, vecs[i].e_stall);
    end

    // Mid-stream reset: fill, stall five cycles, then reset
    @(negedge clk); a_valid = 1; a_data = 64'h61; a_ready = 0; a_flush = 0;
    @(negedge clk); a_data = 64'h62;
    @(negedge clk); a_data = 64'h63;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("pre_rst_count", a_count, 2);
    checkOutput("pre_rst_stall", a_stall, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_valid = 0;
    #1;
    checkOutput("mid_rst_valid_o", a_valid_o, 0);
    checkOutput("mid_rst_ready_o", a_ready_o, 1);
    checkOutput("mid_rst_count_o", a_count, 0);
    checkOutput("mid_rst_stall", a_stall, 0);
    checkOutput("mid_rst_empty_o", a_empty, 1);

    // DEPTH=3 wrap-around with ready_i pattern 1,1,0
    k = 0; got = 0; mcnt = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      b_valid = (k < 10);
      b_data  = 8'(k);
      b_ready = ((cyc % 3) != 2);
      #1;
      exp_ro = (mcnt < 3);
      exp_vo = (mcnt > 0);
      checkOutput("wrap_count_o", b_count, 64'(mcnt));
      checkOutput("wrap_ready_o", b_ready_o, exp_ro);
      checkOutput("wrap_valid_o", b_valid_o, exp_vo);
      acc = b_valid && exp_ro;
      pop = exp_vo && b_ready;
      if (pop) begin
        checkOutput("wrap_order", b_data_o, 64'(got));
        got++;
      end
      if (acc) begin k++; mcnt++; end
      if (pop) mcnt--;
    end
    checkOutput("wrap_all_out", 64'(got), 10);
    @(negedge clk); b_valid = 0; b_ready = 0;

    // Fall-through on an empty buffer
    c_valid = 1; c_data = 8'h55; c_ready = 1;
    #1;
    checkOutput("ft_valid_o", c_valid_o, 1);
    checkOutput("ft_data_o", c_data_o, 8'h55);
    checkOutput("ft_count_o", c_count, 0);
    @(negedge clk); c_valid = 0; c_ready = 0;
    #1;
    checkOutput("ft_after_count", c_count, 0);
    checkOutput("ft_after_valid", c_valid_o, 0);
    @(negedge clk); c_valid = 1; c_data = 8'h66;
    #1;
    checkOutput("ft_nr_data_o", c_data_o, 8'h66);
    @(negedge clk); c_valid = 0; c_ready = 1;
    #1;
    checkOutput("ft_held_count", c_count, 1);
    checkOutput("ft_held_data", c_data_o, 8'h66);
    checkOutput("ft_held_valid", c_valid_o, 1);
    @(negedge clk); c_ready = 0;
    #1;
    checkOutput("ft_drained_empty", c_empty, 1);

    // DEPTH=1 stall counter saturation and clear
    @(negedge clk); d_valid = 1; d_data = 8'h07; d_ready = 0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("stall_mid", d_stall, 9);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("stall_sat", d_stall, 15);
    checkOutput("stall_full", d_full, 1);
    d_clr = 1;
    @(negedge clk); d_clr = 0;
    #1;
    checkOutput("stall_clr", d_stall, 0);
    d_ready = 1;
    @(negedge clk);
    #1;
    checkOutput("d1_freed_count", d_count, 0);
    @(negedge clk); d_valid = 0;
    #1;
    checkOutput("d1_reload_data", d_data_o, 8'h07);
    @(negedge clk); d_ready = 0;
    #1;
    checkOutput("d1_final_empty", d_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
